// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================
// serial_adder_pkg : shared types for the bit-serial adder
// Rev 1.0
// ============================================================
package serial_adder_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width; never below one bit so the counter always exists.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_fsm_fa_bit.sv
`default_nettype none
// ============================================================
// fa_bit : combinational one-bit full adder cell
// Rev 1.0
// ============================================================
module fa_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);

endmodule
`default_nettype wire

// File: rtl/serial_adder_fsm.sv
`default_nettype none
// ============================================================
// serial_adder_fsm : bit-serial add/subtract, one bit per clock
// Rev 1.0
// ============================================================
module serial_adder_fsm
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:1] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_ovf;

  logic             w_sum;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_shift;

  fa_bit u_fa (
    .i_a  (r_a[0]),
    .i_b  (r_b[0]),
    .i_ci (r_carry),
    .o_s  (w_sum),
    .o_co (w_cout)
  );

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  // New sum bit lands on top; on the final bit this is the complete result.
  assign w_shift  = {w_sum, r_res};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last)   w_next = DONE;
      DONE:    w_next = w_accept ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtract is a + ~b + 1, so the carry register supplies the +1.
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : ci;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_res   <= w_shift[WIDTH-1:1];
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_s   <= w_shift;
        r_co  <= w_cout;
        r_ovf <= r_carry ^ w_cout;
      end
    end
  end

  assign s   = r_s;
  assign co  = r_co;
  assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_fsm.sv
`default_nettype none
// ============================================================
// tb_serial_adder_fsm : scoreboard bench for widths 8, 2 and 32
// Rev 1.0
// ============================================================
module tb_serial_adder_fsm;

  typedef struct {
    int          d;
    logic [63:0] s;
    logic        co;
    logic        ovf;
    int          e0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  int   bc[3];
  logic [63:0] hold[3];

  logic        start8 = 0, ci8 = 0, sub8 = 0, busy8, done8, co8, ovf8;
  logic [7:0]  a8 = 0, b8 = 0, s8;
  logic        start2 = 0, ci2 = 0, sub2 = 0, busy2, done2, co2, ovf2;
  logic [1:0]  a2 = 0, b2 = 0, s2;
  logic        start32 = 0, ci32 = 0, sub32 = 0, busy32, done32, co32, ovf32;
  logic [31:0] a32 = 0, b32 = 0, s32;

  serial_adder_fsm #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .ci(ci8), .sub(sub8),
    .busy(busy8), .done(done8), .s(s8), .co(co8), .ovf(ovf8));
  serial_adder_fsm #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .ci(ci2), .sub(sub2),
    .busy(busy2), .done(done2), .s(s2), .co(co2), .ovf(ovf2));
  serial_adder_fsm #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .ci(ci32), .sub(sub32),
    .busy(busy32), .done(done32), .s(s32), .co(co32), .ovf(ovf32));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int d, input logic st, input logic [63:0] a,
                       input logic [63:0] b, input logic ci, input logic sub);
    case (d)
      0: begin start8 = st; a8 = a[7:0]; b8 = b[7:0]; ci8 = ci; sub8 = sub; end
      1: begin start2 = st; a2 = a[1:0]; b2 = b[1:0]; ci2 = ci; sub2 = sub; end
      default: begin start32 = st; a32 = a[31:0]; b32 = b[31:0]; ci32 = ci; sub32 = sub; end
    endcase
  endtask

  task automatic set_start(input int d, input logic st);
    case (d)
      0: start8 = st;
      1: start2 = st;
      default: start32 = st;
    endcase
  endtask

  function automatic logic get_done(input int d);
    case (d)
      0: return done8;
      1: return done2;
      default: return done32;
    endcase
  endfunction

  // Call at a negedge; start is accepted on the following posedge.
  task automatic issue(input int d, input logic [63:0] a, input logic [63:0] b,
                       input logic ci, input logic sub, input logic [63:0] es,
                       input logic eco, input logic eovf, input bit push, input bit keep);
    drive(d, 1'b1, a, b, ci, sub);
    if (push) q.push_back('{d: d, s: es, co: eco, ovf: eovf, e0: cyc + 1});
    if (!keep) begin
      @(negedge clk);
      set_start(d, 1'b0);
    end
  endtask

  task automatic wait_done(input int d);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (get_done(d)) return;
    end
    total++;
    bad++;
    $display("FAIL wait_done dut%0d: got no done within 200 cycles expected done", d);
  endtask

  task automatic mon(input int d, input logic dn, input logic [63:0] s, input logic co,
                     input logic ovf, input logic bsy, input int w);
    exp_t e;
    if (rst) begin
      bc[d] = 0;
      hold[d] = '0;
      return;
    end
    if (bsy) bc[d]++;
    if (dn) begin
      if (q.size() == 0 || q[0].d != d) begin
        total++;
        bad++;
        $display("FAIL unexpected_done dut%0d: got done=1 expected no pending op", d);
      end else begin
        e = q.pop_front();
        chk("sum", s, e.s);
        chk("carry_out", 64'(co), 64'(e.co));
        chk("overflow", 64'(ovf), 64'(e.ovf));
        chk("latency", 64'(cyc - e.e0), 64'(w));
        chk("busy_cycles", 64'(bc[d]), 64'(w));
        hold[d] = e.s;
      end
      bc[d] = 0;
    end else begin
      chk("s_hold", s, hold[d]);
    end
  endtask

  always @(negedge clk) begin
    mon(0, done8, 64'(s8), co8, ovf8, busy8, 8);
    mon(1, done2, 64'(s2), co2, ovf2, busy2, 2);
    mon(2, done32, 64'(s32), co32, ovf32, busy32, 32);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy8", 64'(busy8), 0);
    chk("rst_done8", 64'(done8), 0);
    chk("rst_s8", 64'(s8), 0);
    chk("rst_co8", 64'(co8), 0);
    chk("rst_ovf8", 64'(ovf8), 0);
    chk("rst_busy32", 64'(busy32), 0);
    #1 rst = 1'b0;

    // WIDTH=8 directed adds and subtracts
    @(negedge clk); issue(0, 64'h0F, 64'h01, 0, 0, 64'h10, 0, 0, 1, 0); wait_done(0);
    @(negedge clk); issue(0, 64'hFF, 64'h01, 1, 0, 64'h01, 1, 0, 1, 0); wait_done(0);
    @(negedge clk); issue(0, 64'h7F, 64'h01, 0, 0, 64'h80, 0, 1, 1, 0); wait_done(0);
    @(negedge clk); issue(0, 64'h05, 64'h07, 1, 1, 64'hFE, 0, 0, 1, 0); wait_done(0);
    @(negedge clk); issue(0, 64'h80, 64'h01, 0, 1, 64'h7F, 1, 1, 1, 0); wait_done(0);
    @(negedge clk); issue(0, 64'h33, 64'h33, 0, 1, 64'h00, 1, 0, 1, 0); wait_done(0);

    // Back-to-back: start held, new operands presented in each done cycle
    @(negedge clk);
    issue(0, 64'h12, 64'h34, 0, 0, 64'h46, 0, 0, 1, 1); wait_done(0);
    issue(0, 64'hC8, 64'h64, 0, 0, 64'h2C, 1, 0, 1, 1); wait_done(0);
    issue(0, 64'h10, 64'h20, 0, 1, 64'hF0, 0, 0, 1, 1); wait_done(0);
    issue(0, 64'h40, 64'h40, 0, 0, 64'h80, 0, 1, 1, 1); wait_done(0);
    set_start(0, 1'b0);

    // Start pulse during RUN must be ignored
    @(negedge clk); issue(0, 64'h03, 64'h04, 0, 0, 64'h07, 0, 0, 1, 0);
    @(negedge clk);
    drive(0, 1'b1, 64'h00, 64'h00, 0, 0);
    @(negedge clk);
    set_start(0, 1'b0);
    wait_done(0);

    // Asynchronous reset while bit 3 is pending
    @(negedge clk); issue(0, 64'h11, 64'h22, 0, 0, 64'h0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy8), 0);
    chk("abort_s", 64'(s8), 0);
    chk("abort_done", 64'(done8), 0);
    chk("abort_co_ovf", 64'({co8, ovf8}), 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); issue(0, 64'h0A, 64'h05, 0, 0, 64'h0F, 0, 0, 1, 0); wait_done(0);

    // WIDTH=2
    @(negedge clk); issue(1, 64'h3, 64'h1, 0, 0, 64'h0, 1, 0, 1, 0); wait_done(1);
    @(negedge clk); issue(1, 64'h3, 64'h1, 1, 0, 64'h1, 1, 0, 1, 0); wait_done(1);
    @(negedge clk); issue(1, 64'h1, 64'h1, 0, 0, 64'h2, 0, 1, 1, 0); wait_done(1);

    // WIDTH=32
    @(negedge clk); issue(2, 64'h0000000F, 64'h1, 0, 0, 64'h00000010, 0, 0, 1, 0); wait_done(2);
    @(negedge clk); issue(2, 64'hFFFFFFFF, 64'h1, 1, 0, 64'h00000001, 1, 0, 1, 0); wait_done(2);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
